// File: rtl/iob_cache_fe_arbiter_if.sv
// rtl/iob_cache_fe_arbiter_if.sv - IOb-native bus bundle between two masters, the arbiter and the cache frontend
//
// Signals (arbiter view):
//   m_valid_i[1:0], m_addr_i, m_wdata_i, m_wstrb_i   requests from master 0/1 (packed, master k at slice k)
//   m_ready_o[1:0], m_rvalid_o[1:0], m_rdata_o       handshake and read response back to the masters
//   c_valid_o, c_addr_o, c_wdata_o, c_wstrb_o        request to the cache frontend
//   c_ready_i, c_rvalid_i, c_rdata_i                 cache frontend handshake and read response
// Modports: slave = arbiter side, master = environment (masters + cache) side.
interface iob_cache_fe_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [1:0]              m_valid_i;
    logic [2*ADDR_W-1:0]     m_addr_i;
    logic [2*DATA_W-1:0]     m_wdata_i;
    logic [2*DATA_W/8-1:0]   m_wstrb_i;
    logic [1:0]              m_ready_o;
    logic [1:0]              m_rvalid_o;
    logic [DATA_W-1:0]       m_rdata_o;
    logic                    c_valid_o;
    logic [ADDR_W-1:0]       c_addr_o;
    logic [DATA_W-1:0]       c_wdata_o;
    logic [DATA_W/8-1:0]     c_wstrb_o;
    logic                    c_ready_i;
    logic                    c_rvalid_i;
    logic [DATA_W-1:0]       c_rdata_i;

    modport slave (
        input  m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        output m_ready_o, m_rvalid_o, m_rdata_o,
        output c_valid_o, c_addr_o, c_wdata_o, c_wstrb_o,
        input  c_ready_i, c_rvalid_i, c_rdata_i
    );

    modport master (
        output m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        input  m_ready_o, m_rvalid_o, m_rdata_o,
        input  c_valid_o, c_addr_o, c_wdata_o, c_wstrb_o,
        output c_ready_i, c_rvalid_i, c_rdata_i
    );
endinterface

// File: rtl/iob_cache_fe_arbiter.sv
// rtl/iob_cache_fe_arbiter.sv - two-master arbiter sharing one IOb cache frontend port
//
// Ports:
//   clk_i     clock
//   arst_n_i  asynchronous active-low reset
//   bus       iob_cache_fe_arbiter_if.slave (master requests/responses and cache frontend)
// Configuration:
//   IOB_CACHE_ARB_RR_EN defined   -> round-robin on ties (winner = ~last)
//   IOB_CACHE_ARB_RR_EN undefined -> fixed priority, master 0 wins ties
// One transaction in flight at a time; ready/rvalid are routed combinationally
// to the granted master only.
module iob_cache_fe_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    iob_cache_fe_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_q, last_d;
    logic   win;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;

    assign sel_addr  = gnt_q ? bus.m_addr_i[ADDR_W +: ADDR_W]  : bus.m_addr_i[0 +: ADDR_W];
    assign sel_wdata = gnt_q ? bus.m_wdata_i[DATA_W +: DATA_W] : bus.m_wdata_i[0 +: DATA_W];
    assign sel_wstrb = gnt_q ? bus.m_wstrb_i[STRB_W +: STRB_W] : bus.m_wstrb_i[0 +: STRB_W];

    // Winner is only consumed when at least one request is pending.
`ifdef IOB_CACHE_ARB_RR_EN
    assign win = (&bus.m_valid_i) ? ~last_q : ~bus.m_valid_i[0];
`else
    logic unused_last;
    assign unused_last = last_q;
    assign win = ~bus.m_valid_i[0];
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_d         = last_q;
        bus.m_ready_o  = 2'b00;
        bus.m_rvalid_o = 2'b00;
        bus.m_rdata_o  = bus.c_rdata_i;
        bus.c_valid_o  = 1'b0;
        bus.c_addr_o   = '0;
        bus.c_wdata_o  = '0;
        bus.c_wstrb_o  = '0;

        case (state_q)
            IDLE: begin
                if (|bus.m_valid_i) begin
                    gnt_d   = win;
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.c_valid_o         = 1'b1;
                bus.c_addr_o          = sel_addr;
                bus.c_wdata_o         = sel_wdata;
                bus.c_wstrb_o         = sel_wstrb;
                bus.m_ready_o[gnt_q]  = bus.c_ready_i;
                if (bus.c_ready_i) begin
                    if (|sel_wstrb) begin
                        // Writes have no response phase.
                        last_d  = gnt_q;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                bus.m_rvalid_o[gnt_q] = bus.c_rvalid_i;
                if (bus.c_rvalid_i) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// tb/tb_iob_cache_fe_arbiter.sv - self-checking bench for iob_cache_fe_arbiter
module tb_iob_cache_fe_arbiter;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    iob_cache_fe_arbiter_if #(.ADDR_W(24), .DATA_W(32)) bus ();

    iob_cache_fe_arbiter #(.ADDR_W(24), .DATA_W(32)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  mv;
        logic [3:0]  ws0;
        logic [3:0]  ws1;
        logic        crdy;
        logic        crv;
        logic [31:0] crd;
        logic [1:0]  e_mready;
        logic [1:0]  e_mrvalid;
        logic        e_cvalid;
        logic [23:0] e_caddr;
        logic [31:0] e_cwdata;
        logic [3:0]  e_cwstrb;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input string n, input logic [1:0] mv, input logic [3:0] ws0,
                                input logic [3:0] ws1, input logic crdy, input logic crv,
                                input logic [31:0] crd, input logic [1:0] er, input logic [1:0] erv,
                                input logic ecv, input logic [23:0] ea, input logic [31:0] ewd,
                                input logic [3:0] ews);
        vec_t v;
        v.name = n; v.mv = mv; v.ws0 = ws0; v.ws1 = ws1; v.crdy = crdy; v.crv = crv; v.crd = crd;
        v.e_mready = er; v.e_mrvalid = erv; v.e_cvalid = ecv; v.e_caddr = ea;
        v.e_cwdata = ewd; v.e_cwstrb = ews;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".m_ready"},  {30'd0, bus.m_ready_o},  32'd0);
        chk({tag, ".m_rvalid"}, {30'd0, bus.m_rvalid_o}, 32'd0);
        chk({tag, ".c_valid"},  {31'd0, bus.c_valid_o},  32'd0);
        chk({tag, ".c_addr"},   {8'd0, bus.c_addr_o},    32'd0);
        chk({tag, ".c_wdata"},  bus.c_wdata_o,           32'd0);
        chk({tag, ".c_wstrb"},  {28'd0, bus.c_wstrb_o},  32'd0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        bus.m_valid_i = 2'b00; bus.m_wstrb_i = 8'h00;
        bus.c_ready_i = 1'b0; bus.c_rvalid_i = 1'b0; bus.c_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    // Serve one read for the expected master; caller holds the request inputs.
    task automatic txn(input int exp_m, input logic [23:0] exp_addr, input logic [31:0] rd);
        int n = 0;
        #1;
        while (!bus.c_valid_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("txn.wait_c_valid", {31'd0, bus.c_valid_o}, 32'd1);
        chk("txn.c_addr", {8'd0, bus.c_addr_o}, {8'd0, exp_addr});
        bus.c_ready_i = 1'b1;
        #1 chk("txn.m_ready", {30'd0, bus.m_ready_o}, (exp_m == 1) ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        bus.c_ready_i = 1'b0;
        bus.c_rvalid_i = 1'b1;
        bus.c_rdata_i = rd;
        #1;
        chk("txn.m_rvalid", {30'd0, bus.m_rvalid_o}, (exp_m == 1) ? 32'd2 : 32'd1);
        chk("txn.m_rdata", bus.m_rdata_o, rd);
        @(posedge clk); #1;
        bus.c_rvalid_i = 1'b0;
    endtask

    initial begin
        bus.m_addr_i  = {24'h000008, 24'h000004};
        bus.m_wdata_i = {32'h00000077, 32'h0000000C};

        vecs[0]  = mk("idle",        2'b00, 4'h0, 4'h0, 0, 0, 32'h00, 2'b00, 2'b00, 0, 24'h0, 32'h00, 4'h0);
        vecs[1]  = mk("wr_req",      2'b01, 4'hF, 4'h0, 0, 0, 32'h00, 2'b00, 2'b00, 0, 24'h0, 32'h00, 4'h0);
        vecs[2]  = mk("wr_wait1",    2'b01, 4'hF, 4'h0, 0, 0, 32'h00, 2'b00, 2'b00, 1, 24'h4, 32'h0C, 4'hF);
        vecs[3]  = mk("wr_wait2",    2'b01, 4'hF, 4'h0, 0, 0, 32'h00, 2'b00, 2'b00, 1, 24'h4, 32'h0C, 4'hF);
        vecs[4]  = mk("wr_accept",   2'b01, 4'hF, 4'h0, 1, 0, 32'h00, 2'b01, 2'b00, 1, 24'h4, 32'h0C, 4'hF);
        vecs[5]  = mk("wr_done",     2'b00, 4'h0, 4'h0, 0, 0, 32'h00, 2'b00, 2'b00, 0, 24'h0, 32'h00, 4'h0);
        vecs[6]  = mk("rd1_req",     2'b10, 4'h0, 4'h0, 0, 0, 32'h00, 2'b00, 2'b00, 0, 24'h0, 32'h00, 4'h0);
        vecs[7]  = mk("rd1_accept",  2'b10, 4'h0, 4'h0, 1, 0, 32'h00, 2'b10, 2'b00, 1, 24'h8, 32'h77, 4'h0);
        vecs[8]  = mk("rd1_wait1",   2'b00, 4'h0, 4'h0, 0, 0, 32'h00, 2'b00, 2'b00, 0, 24'h0, 32'h00, 4'h0);
        vecs[9]  = mk("rd1_wait2",   2'b00, 4'h0, 4'h0, 0, 0, 32'h00, 2'b00, 2'b00, 0, 24'h0, 32'h00, 4'h0);
        vecs[10] = mk("rd1_data",    2'b00, 4'h0, 4'h0, 0, 1, 32'h18, 2'b00, 2'b10, 0, 24'h0, 32'h00, 4'h0);
        vecs[11] = mk("stray_idle",  2'b00, 4'h0, 4'h0, 0, 1, 32'h99, 2'b00, 2'b00, 0, 24'h0, 32'h00, 4'h0);
        vecs[12] = mk("post_stray",  2'b01, 4'h0, 4'h0, 0, 0, 32'h00, 2'b00, 2'b00, 0, 24'h0, 32'h00, 4'h0);
        vecs[13] = mk("stray_req",   2'b01, 4'h0, 4'h0, 0, 1, 32'h44, 2'b00, 2'b00, 1, 24'h4, 32'h0C, 4'h0);
        vecs[14] = mk("rd0_accept",  2'b01, 4'h0, 4'h0, 1, 0, 32'h00, 2'b01, 2'b00, 1, 24'h4, 32'h0C, 4'h0);
        vecs[15] = mk("rd0_data",    2'b00, 4'h0, 4'h0, 0, 1, 32'h55, 2'b00, 2'b01, 0, 24'h0, 32'h00, 4'h0);

        do_reset();
        #1 chk_idle_outputs("reset");

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            bus.m_valid_i  = vecs[i].mv;
            bus.m_wstrb_i  = {vecs[i].ws1, vecs[i].ws0};
            bus.c_ready_i  = vecs[i].crdy;
            bus.c_rvalid_i = vecs[i].crv;
            bus.c_rdata_i  = vecs[i].crd;
            #1;
            chk({vecs[i].name, ".m_ready"},  {30'd0, bus.m_ready_o},  {30'd0, vecs[i].e_mready});
            chk({vecs[i].name, ".m_rvalid"}, {30'd0, bus.m_rvalid_o}, {30'd0, vecs[i].e_mrvalid});
            chk({vecs[i].name, ".m_rdata"},  bus.m_rdata_o,           vecs[i].crd);
            chk({vecs[i].name, ".c_valid"},  {31'd0, bus.c_valid_o},  {31'd0, vecs[i].e_cvalid});
            chk({vecs[i].name, ".c_addr"},   {8'd0, bus.c_addr_o},    {8'd0, vecs[i].e_caddr});
            chk({vecs[i].name, ".c_wdata"},  bus.c_wdata_o,           vecs[i].e_cwdata);
            chk({vecs[i].name, ".c_wstrb"},  {28'd0, bus.c_wstrb_o},  {28'd0, vecs[i].e_cwstrb});
        end
        @(posedge clk); #1;
        bus.m_valid_i = 2'b00; bus.c_rvalid_i = 1'b0; bus.c_ready_i = 1'b0;

        // Tie arbitration from a fresh reset (last=1).
        do_reset();
        bus.m_wstrb_i = 8'h00;
        bus.m_valid_i = 2'b11;
`ifdef IOB_CACHE_ARB_RR_EN
        for (int t = 0; t < 8; t++)
            txn(t % 2, (t % 2 == 1) ? 24'h8 : 24'h4, 32'h100 + t);
`else
        for (int t = 0; t < 5; t++)
            txn(0, 24'h4, 32'h200 + t);
        bus.m_valid_i = 2'b10;
        txn(1, 24'h8, 32'h2FF);
`endif
        bus.m_valid_i = 2'b00;

        // Reset asserted while a read response is pending.
        @(posedge clk); #1;
        bus.m_valid_i = 2'b10;
        @(posedge clk); #1;
        bus.c_ready_i = 1'b1;
        #1 chk("rst_mid.accept", {30'd0, bus.m_ready_o}, 32'd2);
        @(posedge clk); #1;
        bus.c_ready_i = 1'b0;
        bus.m_valid_i = 2'b00;
        #2 arst_n = 1'b0;
        bus.c_rvalid_i = 1'b1;
        #1 chk_idle_outputs("rst_mid");
        @(posedge clk); #1;
        bus.c_rvalid_i = 1'b0;
        arst_n = 1'b1;
        bus.m_addr_i = {24'h000010, 24'h000004};
        bus.m_valid_i = 2'b10;
        txn(1, 24'h10, 32'h30);
        bus.m_valid_i = 2'b00;
        @(posedge clk); #1 chk_idle_outputs("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
